// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite responder in front of a simple dual-port synchronous SRAM
// (separate read/write word addresses, one-cycle read latency, byte-enabled
// writes). Address phases are decoded when the bus handshake completes.
// Each accepted transfer then gets WAIT_STATES wait cycles followed by one
// ready cycle. Writes are committed to the SRAM in that ready cycle.
// A read accepted in the same cycle as a write to the same word sees the
// written bytes forwarded into its result.
//
// Optional feature macro: AHB_SRAM_RANGE_CHECK_EN
//   defined   : illegal-size, misaligned and out-of-window transfers get a
//               two-cycle ERROR response (states ERR1/ERR2).
//   undefined : every transfer is OKAY. Sizes above word are treated as
//               word, low address bits are forced to the natural alignment,
//               and addresses wrap modulo the window.
//
// Parameters
//   ADDR_WIDTH  : SRAM word-address bits (window = 4 << ADDR_WIDTH bytes)
//   BASE_ADDR   : byte base of the window, aligned to the window size
//   WAIT_STATES : HREADYOUT-low cycles at the start of each data phase (0..7)
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   HSEL/HADDR/HWRITE/HSIZE/HTRANS AHB address phase
//   HBURST/HMASTLOCK               accepted but unused
//   HWDATA                         AHB data-phase write data
//   HREADYIN                       bus-level HREADY
//   HRDATA/HREADYOUT/HRESP         AHB data-phase response
//   mem_rdaddr/mem_rden/mem_rdata  SRAM read port (data one cycle after rden)
//   mem_wraddr/mem_wdata/
//   mem_byteena/mem_wren           SRAM write port
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HBURST,
    input  logic                  HMASTLOCK,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic [31:0]           HRDATA,
    output logic                  HREADYOUT,
    output logic [1:0]            HRESP,
    output logic [ADDR_WIDTH-1:0] mem_rdaddr,
    output logic                  mem_rden,
    input  logic [31:0]           mem_rdata,
    output logic [ADDR_WIDTH-1:0] mem_wraddr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_byteena,
    output logic                  mem_wren
);

    // First byte-address bit above the window.
    localparam int TAG_LSB = ADDR_WIDTH + 2;

    // The counter is loaded with WAIT_STATES-1 so that the WAIT state is
    // occupied exactly WAIT_STATES cycles.
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
`ifdef AHB_SRAM_RANGE_CHECK_EN
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_t;
`endif

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                  state_q,    state_d;
    logic [2:0]              wait_cnt_q, wait_cnt_d;
    logic                    rd_q,       rd_d;       // read data phase active
    logic                    wr_q,       wr_d;       // write data phase active
    logic                    first_q,    first_d;    // first cycle of a data phase
    logic [ADDR_WIDTH-1:0]   wraddr_q,   wraddr_d;
    logic [3:0]              byteena_q,  byteena_d;
    logic [3:0]              fwd_mask_q, fwd_mask_d; // lanes overridden by a forwarded write
    logic [31:0]             fwd_data_q, fwd_data_d;
    logic [31:0]             rdata_q,    rdata_d;

    // -----------------------------------------------------------------------
    // Address-phase decode
    // -----------------------------------------------------------------------
    logic                  bus_accept;
    logic                  phase_open;
    logic                  take;
    logic                  legal_take;
    logic [2:0]            size_eff;
    logic [1:0]            lane_addr;
    logic [3:0]            lanes;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [31:0]           merged_rdata;
    logic                  unused_inputs;

    assign bus_accept = HSEL && HREADYIN && HTRANS[1];
    // New address phases are only taken when no data phase is stalling;
    // anything sampled in ERR2 is dropped and must be re-issued.
    assign phase_open = (state_q == ST_IDLE) || (state_q == ST_DATA);
    assign take       = bus_accept && phase_open;
    assign word_addr  = HADDR[ADDR_WIDTH+1:2];

`ifdef AHB_SRAM_RANGE_CHECK_EN
    logic addr_err;
    logic err_take;

    assign size_eff  = HSIZE;
    assign lane_addr = HADDR[1:0];
    assign addr_err  = (HSIZE > 3'd2)
                    || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                    || ((HSIZE == 3'd1) && HADDR[0])
                    || (HADDR[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB]);
    assign legal_take = take && !addr_err;
    assign err_take   = take && addr_err;
    assign unused_inputs = ^{HBURST, HMASTLOCK, HTRANS[0]};
`else
    // Without checking, oversize transfers become words and the low address
    // bits are dropped to the natural alignment of the size.
    assign size_eff  = (HSIZE > 3'd2) ? 3'd2 : HSIZE;
    assign lane_addr = (size_eff == 3'd2) ? 2'b00 :
                       (size_eff == 3'd1) ? {HADDR[1], 1'b0} : HADDR[1:0];
    assign legal_take = take;
    assign unused_inputs = ^{HBURST, HMASTLOCK, HTRANS[0], HADDR[31:TAG_LSB]};
`endif

    always_comb begin
        case (size_eff)
            3'd0:    lanes = 4'b0001 << lane_addr;
            3'd1:    lanes = 4'b0011 << {lane_addr[1], 1'b0};
            default: lanes = 4'b1111;
        endcase
    end

    // -----------------------------------------------------------------------
    // SRAM ports
    // -----------------------------------------------------------------------
    assign mem_rden    = legal_take && !HWRITE;
    assign mem_rdaddr  = mem_rden ? word_addr : '0;
    assign mem_wren    = (state_q == ST_DATA) && wr_q;
    assign mem_wraddr  = wraddr_q;
    assign mem_byteena = mem_wren ? byteena_q : 4'b0000;
    assign mem_wdata   = mem_wren ? HWDATA : 32'd0;

    // Lanes written in the read's accept cycle replace the (stale) SRAM lanes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
        assign merged_rdata[8*gi +: 8] = fwd_mask_q[gi] ? fwd_data_q[8*gi +: 8]
                                                        : mem_rdata[8*gi +: 8];
    end

    // SRAM data is only valid in the first data-phase cycle; later cycles
    // (wait states stretching into DATA) replay the captured copy.
    assign HRDATA = rd_q ? (first_q ? merged_rdata : rdata_q) : 32'd0;

    // -----------------------------------------------------------------------
    // Next-state / response logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        first_d    = 1'b0;
        wraddr_d   = wraddr_q;
        byteena_d  = byteena_q;
        fwd_mask_d = fwd_mask_q;
        fwd_data_d = fwd_data_q;
        rdata_d    = rdata_q;
        HREADYOUT  = 1'b1;
        HRESP      = RESP_OKAY;

        if (first_q && rd_q) begin
            rdata_d = merged_rdata;
        end

        case (state_q)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (wait_cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
`ifdef AHB_SRAM_RANGE_CHECK_EN
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                HRESP   = RESP_ERROR;
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
`endif
            default: begin
                // IDLE or the completing DATA cycle: the current data phase
                // ends here, and whatever is sampled now starts the next one.
                state_d = ST_IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                if (legal_take) begin
                    state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;
                    wait_cnt_d = WAIT_LOAD;
                    rd_d       = !HWRITE;
                    wr_d       = HWRITE;
                    first_d    = 1'b1;
                    if (HWRITE) begin
                        wraddr_d  = word_addr;
                        byteena_d = lanes;
                    end else begin
                        // The SRAM returns the pre-write word when read and
                        // written together, so remember what is being written.
                        fwd_mask_d = (mem_wren && (mem_wraddr == word_addr)) ? mem_byteena : 4'b0000;
                        fwd_data_d = HWDATA;
                    end
                end
`ifdef AHB_SRAM_RANGE_CHECK_EN
                else if (err_take) begin
                    state_d = ST_ERR1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 3'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            first_q    <= 1'b0;
            wraddr_q   <= '0;
            byteena_q  <= 4'b0000;
            fwd_mask_q <= 4'b0000;
            fwd_data_q <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            first_q    <= first_d;
            wraddr_q   <= wraddr_d;
            byteena_q  <= byteena_d;
            fwd_mask_q <= fwd_mask_d;
            fwd_data_q <= fwd_data_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule
